// File: rtl/inv_line_rx.sv
`default_nettype none
// ============================================================================
// Module   : inv_line_rx
// Purpose  : Receive end of an inverted UART-style serial line. line_n idles
//            low, start bit is high, stop bit is low. The line is
//            synchronised, re-inverted, start-detected, sampled at mid-bit
//            and deserialised LSB first into DATA_W-bit words.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W        payload bits per frame (1..16)
//   CLKS_PER_BIT  clk cycles per bit (even, >= 4)
//   SYNC_STAGES   synchroniser depth on line_n (>= 2)
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   line_n      in   asynchronous inverted serial line (idle 0)
//   data        out  last good payload, updated only together with valid
//   valid       out  1-cycle pulse, data is new
//   frame_err   out  1-cycle pulse, stop bit was bad
//   parity_err  out  1-cycle pulse, parity bit was bad (0 without parity)
//   busy        out  high whenever the receiver is not in IDLE
// Configuration
//   INV_LINE_RX_PARITY_EN  when defined, an even-parity bit over the payload
//                          follows the last data bit and is checked.
// ============================================================================
module inv_line_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_n,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  // Elaboration-time parameter checks
  generate
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
      $error("inv_line_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if ((DATA_W < 1) || (DATA_W > 16)) begin : g_bad_data_w
      $error("inv_line_rx: DATA_W must be in 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("inv_line_rx: SYNC_STAGES must be >= 2");
    end
  endgenerate

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef INV_LINE_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser: the only crossing from the asynchronous line into clk.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line_n};
    end
  end

  // Restore normal UART polarity: idle 1, start 0, stop 1.
  assign rx = ~sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              par_bad;

`ifndef INV_LINE_RX_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_LINE_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; they are raised only on the stop sample.
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef INV_LINE_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          idx     <= '0;
          if (!rx) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Wait half a bit, then re-check the start bit so that short
        // glitches are rejected and later samples land at mid-bit.
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (!rx) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == FULL_LAST) begin
            bit_cnt    <= '0;
            shift[idx] <= rx;
            if (idx == IDX_LAST) begin
              idx <= '0;
`ifdef INV_LINE_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

`ifdef INV_LINE_RX_PARITY_EN
        // Even parity: payload bits plus parity bit must XOR to 0.
        PARITY: begin
          if (bit_cnt == FULL_LAST) begin
            bit_cnt <= '0;
            par_bad <= rx ^ (^shift);
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif

        // Return to IDLE on the sample itself so the next start bit can be
        // accepted on the following cycle.
        STOP: begin
          if (bit_cnt == FULL_LAST) begin
            bit_cnt   <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= ~rx;
`ifdef INV_LINE_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rx && !par_bad) begin
              data  <= shift;
              valid <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
          idx     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_line_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_line_rx
// Purpose  : Directed self-checking bench for inv_line_rx with DATA_W=8,
//            CLKS_PER_BIT=16, SYNC_STAGES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_line_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk;
  logic          rst_n;
  logic          line_n;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int vectors    = 0;
  int miscompares = 0;

  // Event counters maintained by a monitor sampling on the falling edge.
  int cyc         = 0;
  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int perr_cnt    = 0;
  int overlap_cnt = 0;
  int first_valid_cyc = -1;

  inv_line_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_n    (line_n),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (frame_err)  ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (valid && (frame_err || parity_err)) overlap_cnt = overlap_cnt + 1;
  end

  // Hold line_n at a level for n clock cycles (called at a falling edge).
  task automatic drive(input logic lvl, input int n);
    line_n = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Complete frame on the inverted line: start=1, data bits inverted,
  // optional even-parity bit (inverted), stop=0 when good.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_ok,
                            input logic par_flip);
    drive(1'b1, CPB);
    for (int i = 0; i < DW; i++) drive(~d[i], CPB);
`ifdef INV_LINE_RX_PARITY_EN
    drive(~((^d) ^ par_flip), CPB);
`else
    if (par_flip) line_n = 1'b0;
`endif
    drive(stop_ok ? 1'b0 : 1'b1, CPB);
    line_n = 1'b0;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    line_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
    vectors++; if (valid_cnt !== 0) begin miscompares++; $display("FAIL reset_no_pulses: got %0d valid pulses want 0", valid_cnt); end
  endtask

  task automatic test_single;
    int start_cyc;
    int lat;
    start_cyc       = cyc;
    first_valid_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    lat = first_valid_cyc - start_cyc;
    vectors++; if (valid_cnt !== 1) begin miscompares++; $display("FAIL single_valid_cnt: got %0d want 1", valid_cnt); end
    vectors++; if (data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", data); end
    vectors++; if (first_valid_cyc < 0 || lat < 155 || lat > 157) begin
      miscompares++; $display("FAIL single_latency: got %0d want 156+-1", lat);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_after: busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    // No idle gap between frames: start follows stop directly.
    send_frame(8'hC3, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    vectors++; if (data !== 8'h5A) begin miscompares++; $display("FAIL b2b_data: got %h want 5a", data); end
    vectors++; if (valid_cnt !== 3) begin miscompares++; $display("FAIL b2b_valid_cnt: got %0d want 3", valid_cnt); end
    vectors++; if (ferr_cnt !== 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_glitch;
    int busy_cycles;
    int v0;
    busy_cycles = 0;
    v0 = valid_cnt;
    line_n = 1'b1;
    repeat (3) @(negedge clk);
    line_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    vectors++; if (busy_cycles < 1 || busy_cycles > 12) begin
      miscompares++; $display("FAIL glitch_busy_len: got %0d cycles want 1..12", busy_cycles);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: busy got %b want 0", busy); end
    vectors++; if (valid_cnt !== v0 || ferr_cnt !== 0 || perr_cnt !== 0) begin
      miscompares++; $display("FAIL glitch_no_pulse: valid %0d ferr %0d perr %0d want %0d 0 0",
                              valid_cnt, ferr_cnt, perr_cnt, v0);
    end
  endtask

  task automatic test_frame_err;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    vectors++; if (ferr_cnt !== 1) begin miscompares++; $display("FAIL ferr_cnt: got %0d want 1", ferr_cnt); end
    vectors++; if (valid_cnt !== v0) begin miscompares++; $display("FAIL ferr_no_valid: got %0d want %0d", valid_cnt, v0); end
    vectors++; if (data !== 8'h5A) begin miscompares++; $display("FAIL ferr_data_hold: got %h want 5a", data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int v0;
    // Frame 0xFF cut off halfway through data bit 4.
    drive(1'b1, CPB);
    for (int i = 0; i < 4; i++) drive(1'b0, CPB);
    drive(1'b0, CPB / 2);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_data: got %h want 00", data); end
    vectors++; if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_outputs: busy %b valid %b ferr %b perr %b want 0 0 0 0",
                              busy, valid, frame_err, parity_err);
    end
    @(negedge clk);
    line_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_release_idle: busy got %b want 0", busy); end
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (valid_cnt !== v0 + 1) begin miscompares++; $display("FAIL mid_after_valid: got %0d want %0d", valid_cnt, v0 + 1); end
    vectors++; if (data !== 8'h81) begin miscompares++; $display("FAIL mid_after_data: got %h want 81", data); end
  endtask

`ifdef INV_LINE_RX_PARITY_EN
  task automatic test_parity;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (valid_cnt !== v0 + 1 || data !== 8'h07) begin
      miscompares++; $display("FAIL parity_good: valid %0d data %h want %0d 07", valid_cnt, data, v0 + 1);
    end
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    vectors++; if (perr_cnt !== 1) begin miscompares++; $display("FAIL parity_bad_perr: got %0d want 1", perr_cnt); end
    vectors++; if (valid_cnt !== v0 + 1) begin miscompares++; $display("FAIL parity_bad_valid: got %0d want %0d", valid_cnt, v0 + 1); end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    line_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef INV_LINE_RX_PARITY_EN
    test_parity();
`endif
    vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
